ro_puf_controller: RTL and testbench
====================================

# ro_puf_controller

Sequencer for the ring-oscillator PUF datapath. It takes a 6-bit challenge and drives the oscillator bank's select, bias and enable lines through N_BITS evaluation rounds. In each round it counts rising edges on both oscillator outputs over a fixed window and compares the counts. Each comparison yields one response bit, shifted into a response register; completion is reported with a one-cycle `done` pulse. It sits between the top-level control/LED logic and the RingOsc instance, replacing ad-hoc free-running edge counting.

## Interface
- N_BITS, 8, response bits per challenge (1..32)
- WINDOW, 1000, clock cycles per round with oscillators enabled (≥ 2)
- SETTLE, 4, cycles per round with new sel/bx applied and oscillators disabled before counting (≥ 1)
- CNT_W, 16, edge-counter width

- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  begin evaluation; sampled only in IDLE
- challenge  in  6  challenge word, captured when start is accepted
- ro_out1  in  1  oscillator A output, asynchronous to CLK
- ro_out2  in  1  oscillator B output, asynchronous to CLK
- ro_sel  out  3  oscillator pair select
- ro_bx  out  3  oscillator bias/path select
- ro_en  out  1  oscillator enable, high only in RUN
- busy  out  1  high from start acceptance until the DONE cycle ends
- done  out  1  one-cycle pulse, response valid
- response  out  N_BITS  result, bit 0 = first round

## Operation
- Reset values: ro_sel=0, ro_bx=0, ro_en=0, busy=0, done=0, response=0, round index=0, both counters=0, state=IDLE.
- FSM states and transitions:
  - IDLE: start=1 → capture challenge into chal_q, clear response, round=0 → SETUP.
  - SETUP: SETTLE cycles → RUN.
  - RUN: WINDOW cycles → DRAIN.
  - DRAIN: 2 cycles → COMPARE.
  - COMPARE: 1 cycle; if round==N_BITS-1 → DONE, else round+1 → SETUP.
  - DONE: 1 cycle → IDLE.
- Per-round configuration, registered and held stable SETUP through COMPARE:
  - ro_sel = chal_q[2:0] + round[2:0], mod 8.
  - ro_bx = chal_q[5:3] ^ round[2:0].
- Both counters clear on SETUP entry.
- ro_out1/ro_out2 each pass through a 2-flop synchronizer plus a third flop for edge detection. A rising edge is sync=1 while the previous sample=0.
- Counters increment on detected rising edges in RUN and DRAIN only; DRAIN flushes the synchronizer pipeline. Counters saturate at 2^CNT_W-1 and do not wrap.
- COMPARE: bit = (cnt1 > cnt2). A tie gives 0. The bit is written to response[round].
- response holds its value from DONE until the next accepted start. Bits of the current round and later rounds read 0 while busy.
- start while not in IDLE is ignored. challenge changes after acceptance have no effect.
- RST mid-evaluation: immediate return to reset values, partial response discarded, ro_en drops asynchronously.

## Timing
- Round period P = SETTLE + WINDOW + 3 cycles; defaults give P = 1007.
- busy rises on the edge that samples start.
- done is high for exactly one cycle, beginning N_BITS·P edges after the start-sampling edge; defaults give 8056.
- busy falls on the edge ending DONE. start is accepted again on the next edge, so back-to-back evaluations are separated by one IDLE cycle.
- ro_en is high for exactly WINDOW consecutive cycles per round. It is low in all other states.
- ro_sel/ro_bx change only on SETUP entry, at least SETTLE cycles before ro_en rises.
- Edge-to-count latency is 3 cycles. Edges arriving within the last ≤2 RUN cycles are still counted in DRAIN.

## Test plan
- Reset mid-RUN (round 3): assert RST → ro_en, busy, done, response all 0 in the same cycle; a new start then runs 8 full rounds.
- Basic evaluation (WINDOW=100, SETTLE=4, N_BITS=8): model ro_out1 with period 4 CLK (25 edges/window) and ro_out2 with period 6 (16–17 edges) → response=8'hFF, done at edge 8·107=856 after the start edge, a single pulse.
- Inverted speeds (ro_out1 period 6, ro_out2 period 4) → response=8'h00. Model sel-dependent speeds (out1 faster only when ro_sel is odd) with challenge=6'b000_000 → response=8'hAA.
- Config sequencing with challenge=6'b101_110: round 0 gives ro_sel=6, ro_bx=5; round 1 gives 7, 4; round 2 gives 0, 7. Each is stable whenever ro_en=1, and ro_en is high for exactly 100 cycles per round.
- Ties and saturation: identical oscillators → every bit 0. With CNT_W=4 and both outputs at period 2 → both counters stick at 15 (no wrap), bit 0.
- Protocol: start pulsed during busy → ignored, no restart and unchanged result. start held high continuously → evaluations repeat with one IDLE cycle between done and the next busy.

Source files
------------

// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF sequencer: walks N_BITS rounds of settle/count/compare
// over the oscillator bank and assembles the response word.
module ro_puf_controller #(
    parameter int N_BITS = 8,
    parameter int WINDOW = 1000,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [5:0]        challenge,
    input  logic              ro_out1,
    input  logic              ro_out2,
    output logic [2:0]        ro_sel,
    output logic [2:0]        ro_bx,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] response
);
    // state   | meaning
    // IDLE    | waiting for start
    // SETUP   | new sel/bx applied, oscillators off, SETTLE cycles
    // RUN     | oscillators on, counting, WINDOW cycles
    // DRAIN   | oscillators off, synchronizer flush still counting, 2 cycles
    // COMPARE | response[round] <= cnt1 > cnt2
    // DONE    | one-cycle done pulse

    localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W = $clog2(TMAX);
    localparam int RND_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RND_W-1:0]  round_q, round_d, round_nx;
    logic [5:0]        chal_q, chal_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        bx_q, bx_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic [CNT_W-1:0]  cnt2_q, cnt2_d;
    logic [N_BITS-1:0] resp_q, resp_d;
    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        sync2_q, sync2_d;
    logic              rise1, rise2, counting;

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
        round_d  = round_q;
        round_nx = round_q + RND_W'(1);
        chal_d   = chal_q;
        sel_d    = sel_q;
        bx_d     = bx_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        resp_d   = resp_q;

        // two sync stages plus one history stage for rising-edge detection
        sync1_d  = {sync1_q[1:0], ro_out1};
        sync2_d  = {sync2_q[1:0], ro_out2};
        rise1    = sync1_q[1] & ~sync1_q[2];
        rise2    = sync2_q[1] & ~sync2_q[2];
        counting = (state_q == S_RUN) || (state_q == S_DRAIN);

        if (counting && rise1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
        if (counting && rise2 && (cnt2_q != '1)) cnt2_d = cnt2_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    resp_d  = '0;
                    round_d = '0;
                    sel_d   = challenge[2:0];
                    bx_d    = challenge[5:3];
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    timer_d = TMR_W'(SETTLE - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(WINDOW - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                for (int i = 0; i < N_BITS; i++) begin
                    if (round_q == RND_W'(i)) resp_d[i] = (cnt1_q > cnt2_q);
                end
                if (round_q == RND_W'(N_BITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_nx;
                    sel_d   = chal_q[2:0] + round_nx[2:0];
                    bx_d    = chal_q[5:3] ^ round_nx[2:0];
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    timer_d = TMR_W'(SETTLE - 1);
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            round_q <= '0;
            chal_q  <= '0;
            sel_q   <= '0;
            bx_q    <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            resp_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            round_q <= round_d;
            chal_q  <= chal_d;
            sel_q   <= sel_d;
            bx_q    <= bx_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            resp_q  <= resp_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // decoded straight from the state flop so reset drops ro_en without a clock
    assign ro_en    = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ro_sel   = sel_q;
    assign ro_bx    = bx_q;
    assign response = resp_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: an oscillator-bank model whose speed depends on
// sel/bx, with expected responses derived from challenge arithmetic.
module tb_ro_puf_controller;
    localparam int W  = 100;
    localparam int S  = 4;
    localparam int NB = 8;
    localparam int P  = S + W + 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start, start_s;
    logic [5:0]    challenge, challenge_s;
    logic          ro_out1 = 1'b0, ro_out2 = 1'b0;
    logic          ro_out1_s = 1'b0, ro_out2_s = 1'b0;
    logic [2:0]    ro_sel, ro_bx, ro_sel_s, ro_bx_s;
    logic          ro_en, busy, done, ro_en_s, busy_s, done_s;
    logic [NB-1:0] response;
    logic [3:0]    response_s;

    int vectors = 0;
    int miscompares = 0;

    int p1[64], p2[64];
    int s_p1 = 2, s_p2 = 2;
    int k1 = 0, k2 = 0;
    logic [5:0] osc_idx;

    int eval_id = 0, seen_id = 0;
    int mon_r = 0, cur_len = 0;
    int len_seen[16];
    logic [2:0] sel_seen[16], bx_seen[16];
    logic stable[16];

    ro_puf_controller #(.N_BITS(NB), .WINDOW(W), .SETTLE(S), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .challenge(challenge),
        .ro_out1(ro_out1), .ro_out2(ro_out2), .ro_sel(ro_sel), .ro_bx(ro_bx),
        .ro_en(ro_en), .busy(busy), .done(done), .response(response));

    ro_puf_controller #(.N_BITS(4), .WINDOW(W), .SETTLE(S), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .start(start_s), .challenge(challenge_s),
        .ro_out1(ro_out1_s), .ro_out2(ro_out2_s), .ro_sel(ro_sel_s), .ro_bx(ro_bx_s),
        .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s));

    always #5 CLK = ~CLK;

    // oscillator bank: square wave restarting low->high when enabled
    always @(negedge CLK) begin
        if (!ro_en) begin
            k1 = 0; ro_out1 = 1'b0; ro_out2 = 1'b0;
        end else begin
            osc_idx = {ro_sel, ro_bx};
            ro_out1 = (k1 % p1[osc_idx]) < (p1[osc_idx] / 2);
            ro_out2 = (k1 % p2[osc_idx]) < (p2[osc_idx] / 2);
            k1++;
        end
    end

    always @(negedge CLK) begin
        if (!ro_en_s) begin
            k2 = 0; ro_out1_s = 1'b0; ro_out2_s = 1'b0;
        end else begin
            ro_out1_s = (k2 % s_p1) < (s_p1 / 2);
            ro_out2_s = (k2 % s_p2) < (s_p2 / 2);
            k2++;
        end
    end

    // records each ro_en burst: length, config at rise, and config stability
    always @(negedge CLK) begin
        if (eval_id != seen_id) begin
            seen_id = eval_id; mon_r = 0; cur_len = 0;
        end
        if (ro_en) begin
            if (cur_len == 0) begin
                if (mon_r < 16) begin
                    sel_seen[mon_r] = ro_sel; bx_seen[mon_r] = ro_bx; stable[mon_r] = 1'b1;
                end
            end else if (mon_r < 16 && (ro_sel != sel_seen[mon_r] || ro_bx != bx_seen[mon_r])) begin
                stable[mon_r] = 1'b0;
            end
            cur_len++;
        end else if (cur_len != 0) begin
            if (mon_r < 16) len_seen[mon_r] = cur_len;
            mon_r++;
            cur_len = 0;
        end
    end

    function automatic int edges(input int per);
        return (W + per - 1) / per;
    endfunction

    function automatic logic [NB-1:0] model(input logic [5:0] c);
        logic [2:0] sel, bx;
        model = '0;
        for (int r = 0; r < NB; r++) begin
            sel = c[2:0] + 3'(r);
            bx  = c[5:3] ^ 3'(r);
            model[r] = edges(p1[{sel, bx}]) > edges(p2[{sel, bx}]);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tables(input int a, input int b);
        for (int i = 0; i < 64; i++) begin p1[i] = a; p2[i] = b; end
    endtask

    task automatic set_sel_dep();
        for (int i = 0; i < 64; i++) begin
            p1[i] = ((i >> 3) % 2 == 1) ? 4 : 6;
            p2[i] = ((i >> 3) % 2 == 1) ? 6 : 4;
        end
    endtask

    task automatic check_rounds(input logic [5:0] ch);
        logic [2:0] es, eb;
        chk("en_burst_count", mon_r, NB);
        for (int r = 0; r < NB; r++) begin
            es = ch[2:0] + 3'(r);
            eb = ch[5:3] ^ 3'(r);
            chk("en_len", len_seen[r], W);
            chk("cfg_stable", stable[r], 1);
            chk("ro_sel", sel_seen[r], es);
            chk("ro_bx", bx_seen[r], eb);
        end
    endtask

    // one evaluation; pulse_at >= 0 injects a start pulse (other challenge) mid-run
    task automatic run_eval(input logic [5:0] ch, input logic [NB-1:0] exp_resp, input int pulse_at);
        int lat;
        @(negedge CLK); eval_id++; start = 1'b1; challenge = ch;
        @(negedge CLK); start = 1'b0; challenge = 6'($urandom);
        chk("busy_rise", busy, 1);
        lat = 0;
        while (!done && lat < 3000) begin
            @(negedge CLK);
            lat++;
            start = (lat == pulse_at);
            if (start) challenge = ch ^ 6'h01;
        end
        start = 1'b0;
        chk("done_latency", lat, NB * P);
        chk("response", response, exp_resp);
        @(negedge CLK);
        chk("done_single", done, 0);
        chk("busy_fall", busy, 0);
        chk("response_hold", response, exp_resp);
        check_rounds(ch);
    endtask

    task automatic run_sat(input int a, input int b);
        int lat, ca, cb;
        logic [3:0] exp;
        s_p1 = a; s_p2 = b;
        ca = (edges(a) > 15) ? 15 : edges(a);
        cb = (edges(b) > 15) ? 15 : edges(b);
        exp = (ca > cb) ? 4'hF : 4'h0;
        @(negedge CLK); start_s = 1'b1; challenge_s = 6'($urandom);
        @(negedge CLK); start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 3000) begin @(negedge CLK); lat++; end
        chk("sat_latency", lat, 4 * P);
        chk("sat_response", response_s, exp);
        @(negedge CLK);
    endtask

    initial begin
        logic [5:0] ch;
        int lat;
        RST = 1'b1; start = 1'b0; challenge = '0; start_s = 1'b0; challenge_s = '0;
        set_tables(4, 6);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_sel", ro_sel, 0);
        chk("rst_bx", ro_bx, 0);
        chk("rst_en", ro_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_response", response, 0);

        // reset in round 3 RUN
        @(negedge CLK); start = 1'b1; challenge = 6'h15;
        @(negedge CLK); start = 1'b0;
        repeat (3 * P + S + 19) @(negedge CLK);
        chk("mid_run_en", ro_en, 1);
        chk("partial_response", response, 8'h07);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_en", ro_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_response", response, 0);
        @(negedge CLK); RST = 1'b0;
        run_eval(6'h15, 8'hFF, -1);

        set_tables(6, 4);
        run_eval(6'h2A, 8'h00, -1);

        set_sel_dep();
        run_eval(6'b000_000, 8'hAA, -1);

        set_tables(4, 6);
        run_eval(6'b101_110, 8'hFF, -1);
        chk("cfg_r0_sel", sel_seen[0], 6); chk("cfg_r0_bx", bx_seen[0], 5);
        chk("cfg_r1_sel", sel_seen[1], 7); chk("cfg_r1_bx", bx_seen[1], 4);
        chk("cfg_r2_sel", sel_seen[2], 0); chk("cfg_r2_bx", bx_seen[2], 7);

        set_tables(5, 5);
        run_eval(6'h3F, 8'h00, -1);

        set_sel_dep();
        run_eval(6'h00, 8'hAA, 300);

        // start held high: repeat with one IDLE cycle between evaluations
        @(negedge CLK); eval_id++; start = 1'b1; challenge = 6'h00;
        @(negedge CLK);
        lat = 0;
        while (!done && lat < 3000) begin @(negedge CLK); lat++; end
        chk("held_latency1", lat, NB * P);
        chk("held_response1", response, 8'hAA);
        @(negedge CLK);
        chk("held_idle_gap", busy, 0);
        @(negedge CLK);
        chk("held_restart", busy, 1);
        lat = 0;
        while (!done && lat < 3000) begin @(negedge CLK); lat++; end
        start = 1'b0;
        chk("held_latency2", lat, NB * P);
        chk("held_response2", response, 8'hAA);
        @(negedge CLK);

        repeat (5) begin
            for (int i = 0; i < 64; i++) begin
                p1[i] = int'($urandom_range(12, 2));
                p2[i] = int'($urandom_range(12, 2));
            end
            ch = 6'($urandom);
            run_eval(ch, model(ch), -1);
        end

        run_sat(2, 2);
        run_sat(2, 6);
        run_sat(6, 2);
        run_sat(8, 12);
        run_sat(12, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
